quad_step_decoder: RTL and testbench

//  Front-end stage for the up/down counter. Turns the raw 2-channel quadrature

---
 rtl/quad_pkg.sv | 34 +++
 rtl/quad_step_decoder_if.sv | 12 +
 rtl/quad_pin_cond.sv | 53 +++++
 rtl/quad_step_decoder.sv | 109 ++++++++++
 tb/tb_quad_step_decoder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/quad_pkg.sv
// Shared AB state encodings, step classification and the Gray-code transition decoder.
// Pure combinational helpers; no latency, no backpressure.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Forward order is 00->01->11->10->00; any other single-bit change is reverse.
  function automatic step_t step_of(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if ((prev ^ cur) == 2'b11) begin
      s = STEP_ERR;
    end else if (prev != cur) begin
      case (prev)
        S00:     s = (cur == S01) ? STEP_FWD : STEP_REV;
        S01:     s = (cur == S11) ? STEP_FWD : STEP_REV;
        S11:     s = (cur == S10) ? STEP_FWD : STEP_REV;
        default: s = (cur == S00) ? STEP_FWD : STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder pins in, step/error pulses out; the decoder takes the slave side.
// No handshake: pulses are fire-and-forget, there is no backpressure.
interface quad_step_decoder_if;
  logic enc_a;
  logic enc_b;
  logic up;
  logic down;
  logic err;

  modport master (output enc_a, output enc_b, input up, input down, input err);
  modport slave  (input enc_a, input enc_b, output up, output down, output err);
endinterface

// File: rtl/quad_pin_cond.sv
// One encoder channel: SYNC_STAGES-flop synchroniser, plus a FILT_LEN glitch filter under QUAD_STEP_FILTER_EN.
// Latency SYNC_STAGES edges (+FILT_LEN with filter); no backpressure.
module quad_pin_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("quad_pin_cond: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
    end
  end

`ifdef QUAD_STEP_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // Counts consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      filt <= sync[SYNC_STAGES-1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign level = filt;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: sync/filter pins, Gray decode, divide sub-steps to detent up/down pulses (QUAD_STEP_FILTER_EN adds a filter).
// Latency SYNC_STAGES+1 edges (+FILT_LEN with filter); no backpressure, outputs are 1-cycle pulses.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STEP_DIV    = 4,
  parameter int FILT_LEN    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  quad_step_decoder_if.slave  qif
);

  if (STEP_DIV != 1 && STEP_DIV != 2 && STEP_DIV != 4) begin : g_bad_div
    $error("quad_step_decoder: STEP_DIV must be 1, 2 or 4");
  end

  localparam int AW = $clog2(STEP_DIV) + 1;
  localparam logic signed [AW-1:0] ACC_MAX = AW'(STEP_DIV - 1);
  localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [AW-1:0] ACC_ONE = AW'(1);

  logic                 lvl_a;
  logic                 lvl_b;
  logic [1:0]           cur;
  logic [1:0]           prev;
  logic                 init_done;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic                 up_nxt;
  logic                 down_nxt;
  logic                 err_nxt;
  logic                 up_q;
  logic                 down_q;
  logic                 err_q;
  step_t                step;

  quad_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_pin_a (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (qif.enc_a),
    .level (lvl_a)
  );

  quad_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_pin_b (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (qif.enc_b),
    .level (lvl_b)
  );

  assign cur  = {lvl_a, lvl_b};
  assign step = step_of(prev, cur);

  // A reversal inside a detent just walks acc back toward zero, so partial detents cancel silently.
  always_comb begin
    acc_nxt  = acc;
    up_nxt   = 1'b0;
    down_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (init_done) begin
      case (step)
        STEP_FWD: begin
          if (acc == ACC_MAX) begin
            up_nxt  = 1'b1;
            acc_nxt = '0;
          end else begin
            acc_nxt = acc + ACC_ONE;
          end
        end
        STEP_REV: begin
          if (acc == ACC_MIN) begin
            down_nxt = 1'b1;
            acc_nxt  = '0;
          end else begin
            acc_nxt = acc - ACC_ONE;
          end
        end
        STEP_ERR: err_nxt = 1'b1;
        default:  ;
      endcase
    end
  end

  // The first clock after reset only captures the current pin state as the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      prev      <= S00;
      acc       <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      init_done <= 1'b1;
      prev      <= cur;
      acc       <= acc_nxt;
      up_q      <= up_nxt;
      down_q    <= down_nxt;
      err_q     <= err_nxt;
    end
  end

  assign qif.up   = up_q;
  assign qif.down = down_q;
  assign qif.err  = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench: a STEP_DIV=4 and a STEP_DIV=1 decoder share the same encoder pins.
module tb_quad_step_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 4;
`ifdef QUAD_STEP_FILTER_EN
  localparam int LAT = SYNC + 1 + FILT;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  always #5 clk = ~clk;

  quad_step_decoder_if if4 ();
  quad_step_decoder_if if1 ();

  assign if4.enc_a = enc_a;
  assign if4.enc_b = enc_b;
  assign if1.enc_a = enc_a;
  assign if1.enc_b = enc_b;

  quad_step_decoder #(.SYNC_STAGES(SYNC), .STEP_DIV(4), .FILT_LEN(FILT)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .qif   (if4)
  );

  quad_step_decoder #(.SYNC_STAGES(SYNC), .STEP_DIV(1), .FILT_LEN(FILT)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .qif   (if1)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Running pulse-cycle counts, sampled on the falling edge.
  int up4_n = 0, dn4_n = 0, er4_n = 0;
  int up1_n = 0, dn1_n = 0, er1_n = 0;
  int overlap_n = 0;

  always @(negedge clk) begin
    if (if4.up)   up4_n++;
    if (if4.down) dn4_n++;
    if (if4.err)  er4_n++;
    if (if1.up)   up1_n++;
    if (if1.down) dn1_n++;
    if (if1.err)  er1_n++;
    if (int'(if4.up) + int'(if4.down) + int'(if4.err) > 1) overlap_n++;
    if (int'(if1.up) + int'(if1.down) + int'(if1.err) > 1) overlap_n++;
  end

  typedef struct {
    logic [1:0] ab;
    int         cyc;
    int         up4, dn4, er4;
    int         up1, dn1, er1;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply_ab(input logic [1:0] ab);
    @(negedge clk);
    #1;
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int b_u4, b_d4, b_e4, b_u1, b_d1, b_e1;
    apply_ab(v.ab);
    b_u4 = up4_n; b_d4 = dn4_n; b_e4 = er4_n;
    b_u1 = up1_n; b_d1 = dn1_n; b_e1 = er1_n;
    repeat (v.cyc) @(negedge clk);
    #1;
    check({tag, " up4"},  up4_n - b_u4, v.up4);
    check({tag, " dn4"},  dn4_n - b_d4, v.dn4);
    check({tag, " err4"}, er4_n - b_e4, v.er4);
    check({tag, " up1"},  up1_n - b_u1, v.up1);
    check({tag, " dn1"},  dn1_n - b_d1, v.dn1);
    check({tag, " err1"}, er1_n - b_e1, v.er1);
  endtask

  // Pin change lands just before edge 1; the STEP_DIV=1 pulse must appear only after edge LAT.
  task automatic lat_step(input string tag, input logic [1:0] ab, input bit fwd);
    apply_ab(ab);
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s up1 e%0d", tag, e),   int'(if1.up),   (fwd && e == LAT) ? 1 : 0);
      check($sformatf("%s down1 e%0d", tag, e), int'(if1.down), (!fwd && e == LAT) ? 1 : 0);
    end
  endtask

  function automatic int any_out();
    return int'(if4.up | if4.down | if4.err | if1.up | if1.down | if1.err);
  endfunction

  vec_t tbl[19];

  initial begin
    //          ab    cyc up4 dn4 er4 up1 dn1 er1
    tbl[0]  = '{2'b00, 20, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{2'b01, 20, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{2'b11, 20, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{2'b10, 20, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{2'b00, 20, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{2'b10, 20, 0, 0, 0, 0, 1, 0};
    tbl[6]  = '{2'b11, 20, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{2'b01, 20, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{2'b00, 20, 0, 1, 0, 0, 1, 0};
    tbl[9]  = '{2'b01, 20, 0, 0, 0, 1, 0, 0};
    tbl[10] = '{2'b11, 20, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{2'b01, 20, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{2'b00, 20, 0, 0, 0, 0, 1, 0};
    tbl[13] = '{2'b11, 20, 0, 0, 1, 0, 0, 1};
    tbl[14] = '{2'b10, 20, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{2'b00, 20, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{2'b01, 20, 0, 0, 0, 1, 0, 0};
    tbl[17] = '{2'b11, 20, 1, 0, 0, 1, 0, 0};
    tbl[18] = '{2'b00, 20, 0, 0, 1, 0, 0, 1};

    rst_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", any_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Latency on the STEP_DIV=1 instance, one forward sub-step at a time.
    lat_step("lat 00->01", 2'b01, 1'b1);
    lat_step("lat 01->11", 2'b11, 1'b1);
    lat_step("lat 11->10", 2'b10, 1'b1);
    lat_step("lat 10->00", 2'b00, 1'b1);
    run_vec("settle", '{2'b00, 20, 0, 0, 0, 0, 0, 0});

    // Three sub-steps into a detent, then reset: the partial detent must be lost.
    run_vec("pre-rst 01", '{2'b01, 20, 0, 0, 0, 1, 0, 0});
    run_vec("pre-rst 11", '{2'b11, 20, 0, 0, 0, 1, 0, 0});
    run_vec("pre-rst 10", '{2'b10, 20, 0, 0, 0, 1, 0, 0});
    @(negedge clk);
    rst_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid reset out c%0d", c), any_out(), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post-rst 00", '{2'b00, 20, 0, 0, 0, 0, 0, 0});
    run_vec("post-rst 01", '{2'b01, 20, 0, 0, 0, 1, 0, 0});
    run_vec("post-rst 11", '{2'b11, 20, 0, 0, 0, 1, 0, 0});
    run_vec("post-rst 10", '{2'b10, 20, 0, 0, 0, 1, 0, 0});
    run_vec("post-rst 00b", '{2'b00, 20, 1, 0, 0, 1, 0, 0});

`ifdef QUAD_STEP_FILTER_EN
    // A 2-cycle glitch on A must vanish; a held change is accepted after the filter delay.
    apply_ab(2'b10);
    repeat (2) @(negedge clk);
    #1;
    enc_a = 1'b0;
    run_vec("glitch", '{2'b00, 20, 0, 0, 0, 0, 0, 0});
    lat_step("filt 00->10", 2'b10, 1'b0);
    run_vec("filt back", '{2'b00, 20, 0, 0, 0, 1, 0, 0});
`endif

    check("exclusive outputs", overlap_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
    $fatal(1);
  end

endmodule
